clk_div_ratio_ctrl: RTL and testbench

CLK_DIV_RATIO_CTRL -- requirements
Module: clk_div_ratio_ctrl

---
 rtl/clk_div_ctrl_pkg.sv | 20 ++
 rtl/clk_div_gate_timer.sv | 33 +++
 rtl/clk_div_ratio_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_clk_div_ratio_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the divider ratio controller: FSM states, minimum legal ratio and the pending-request slot.
// The slot ratio field is sized for the widest supported RATIO_WIDTH.
package clk_div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GATE = 2'd2,
      ST_LOAD = 2'd3
   } ctrl_state_e;

   localparam int MIN_VALID_RATIO = 2;
   localparam int PEND_RATIO_W    = 16;

   typedef struct packed {
      logic                    vld;
      logic [PEND_RATIO_W-1:0] ratio;
   } pend_req_t;

endpackage

// File: rtl/clk_div_gate_timer.sv
// Gate-phase countdown: load sets GATE_CYCLES-1, enable decrements to 0, expired flags the final gate cycle.
// Single clock, synchronous active-high reset; no backpressure.
module clk_div_gate_timer #(
   parameter int GATE_CYCLES = 3
) (
   input  logic i_ref_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

   if (GATE_CYCLES < 1) begin : g_bad_gate_cycles
      $error("clk_div_gate_timer: GATE_CYCLES must be at least 1");
   end

   logic [CW-1:0] cnt_q;

   always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (i_load) begin
         cnt_q <= CW'(GATE_CYCLES - 1);
      end else if (i_enable && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Glitch-safe ratio switcher for a downstream clock divider; CLK_DIV_CTRL_GATED_SWITCH_EN adds a GATE phase holding the enable low.
// Registered outputs; a RUN switch takes GATE_CYCLES+2 cycles (2 without the gate), requests during a switch wait in a 1-deep slot.
module clk_div_ratio_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int RATIO_WIDTH   = 8,
   parameter int DEFAULT_RATIO = 8,
   parameter int GATE_CYCLES   = 3
) (
   input  logic                   i_ref_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic                   i_cfg_valid,
   input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
   input  logic                   i_err_clr,
   output logic [RATIO_WIDTH-1:0] o_div_ratio,
   output logic                   o_clk_en,
   output logic                   o_busy,
   output logic                   o_update_done,
   output logic                   o_cfg_err
);

   if (RATIO_WIDTH < 2 || RATIO_WIDTH > PEND_RATIO_W) begin : g_bad_width
      $error("clk_div_ratio_ctrl: RATIO_WIDTH out of supported range");
   end
   if (DEFAULT_RATIO < MIN_VALID_RATIO || DEFAULT_RATIO >= (1 << RATIO_WIDTH)) begin : g_bad_default
      $error("clk_div_ratio_ctrl: DEFAULT_RATIO is not a legal ratio");
   end

   ctrl_state_e            state_q;
   logic [RATIO_WIDTH-1:0] ratio_q;
   logic                   clk_en_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;
   pend_req_t              pend_q;

   logic                   cfg_good;
   logic                   cfg_bad;
   logic                   req_vld;
   logic [RATIO_WIDTH-1:0] req_ratio;
   logic                   switch_req;
   logic                   unused_pend;

   assign cfg_good   = i_cfg_valid && (i_cfg_ratio >= RATIO_WIDTH'(MIN_VALID_RATIO));
   assign cfg_bad    = i_cfg_valid && !cfg_good;
   assign unused_pend = ^pend_q.ratio;

   // A live request supersedes a held one, matching the slot's overwrite rule.
   always_comb begin
      req_vld   = 1'b0;
      req_ratio = i_cfg_ratio;
      if (cfg_good) begin
         req_vld   = 1'b1;
         req_ratio = i_cfg_ratio;
      end else if (pend_q.vld) begin
         req_vld   = 1'b1;
         req_ratio = pend_q.ratio[RATIO_WIDTH-1:0];
      end
   end

   assign switch_req = req_vld && (req_ratio != ratio_q);

`ifdef CLK_DIV_CTRL_GATED_SWITCH_EN
   logic                   gate_load;
   logic                   gate_expired;
   logic [RATIO_WIDTH-1:0] tgt_q;

   assign gate_load = (state_q == ST_RUN) && switch_req;

   clk_div_gate_timer #(
      .GATE_CYCLES (GATE_CYCLES)
   ) u_gate_timer (
      .i_ref_clk (i_ref_clk),
      .i_rst     (i_rst),
      .i_load    (gate_load),
      .i_enable  (state_q == ST_GATE),
      .o_expired (gate_expired)
   );
`else
   localparam int unused_gate_cycles = GATE_CYCLES;
`endif

   always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         ratio_q  <= RATIO_WIDTH'(DEFAULT_RATIO);
         clk_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         pend_q   <= '0;
`ifdef CLK_DIV_CTRL_GATED_SWITCH_EN
         tgt_q    <= RATIO_WIDTH'(DEFAULT_RATIO);
`endif
      end else begin
         done_q <= 1'b0;
         if (cfg_bad) begin
            err_q <= 1'b1;
         end else if (i_err_clr) begin
            err_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               pend_q.vld <= 1'b0;
               if (req_vld) begin
                  ratio_q <= req_ratio;
                  done_q  <= 1'b1;
               end
               if (i_enable) begin
                  state_q  <= ST_RUN;
                  clk_en_q <= 1'b1;
               end
            end

            ST_RUN: begin
               pend_q.vld <= 1'b0;
               if (switch_req) begin
                  busy_q <= 1'b1;
`ifdef CLK_DIV_CTRL_GATED_SWITCH_EN
                  state_q  <= ST_GATE;
                  clk_en_q <= 1'b0;
                  tgt_q    <= req_ratio;
`else
                  state_q  <= ST_LOAD;
                  ratio_q  <= req_ratio;
`endif
               end else begin
                  if (req_vld) begin
                     done_q <= 1'b1;
                  end
                  if (!i_enable) begin
                     state_q  <= ST_IDLE;
                     clk_en_q <= 1'b0;
                  end
               end
            end

`ifdef CLK_DIV_CTRL_GATED_SWITCH_EN
            ST_GATE: begin
               if (cfg_good) begin
                  pend_q.vld   <= 1'b1;
                  pend_q.ratio <= PEND_RATIO_W'(i_cfg_ratio);
               end
               if (gate_expired) begin
                  state_q <= ST_LOAD;
                  ratio_q <= tgt_q;
               end
            end
`endif

            // The switch always completes; i_enable only picks where it lands.
            ST_LOAD: begin
               if (cfg_good) begin
                  pend_q.vld   <= 1'b1;
                  pend_q.ratio <= PEND_RATIO_W'(i_cfg_ratio);
               end
               busy_q <= 1'b0;
               done_q <= 1'b1;
               if (i_enable) begin
                  state_q  <= ST_RUN;
                  clk_en_q <= 1'b1;
               end else begin
                  state_q  <= ST_IDLE;
                  clk_en_q <= 1'b0;
               end
            end

            default: begin
               state_q  <= ST_IDLE;
               clk_en_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign o_div_ratio   = ratio_q;
   assign o_clk_en      = clk_en_q;
   assign o_busy        = busy_q;
   assign o_update_done = done_q;
   assign o_cfg_err     = err_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench for clk_div_ratio_ctrl; expectations follow CLK_DIV_CTRL_GATED_SWITCH_EN (G = gate length, 0 when absent).
module tb_clk_div_ratio_ctrl;

`ifdef CLK_DIV_CTRL_GATED_SWITCH_EN
   localparam int G = 3;
`else
   localparam int G = 0;
`endif
   localparam int D = (G > 0) ? 2 : 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_ratio = 8'd0;
   logic       err_clr = 1'b0;
   logic [7:0] div_ratio;
   logic       clk_en, busy, update_done, cfg_err;

   int checks = 0;
   int failures = 0;

   logic [11:0] got;
   logic [11:0] exp_v;
   assign got = {clk_en, busy, update_done, cfg_err, div_ratio};

   always #5 clk = ~clk;

   clk_div_ratio_ctrl dut (
      .i_ref_clk     (clk),
      .i_rst         (rst),
      .i_enable      (enable),
      .i_cfg_valid   (cfg_valid),
      .i_cfg_ratio   (cfg_ratio),
      .i_err_clr     (err_clr),
      .o_div_ratio   (div_ratio),
      .o_clk_en      (clk_en),
      .o_busy        (busy),
      .o_update_done (update_done),
      .o_cfg_err     (cfg_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; cfg_valid = 1'b1; cfg_ratio = 8'd1;
      step(); step();
      exp_v = {4'b0000, 8'd8};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, exp_v); end
      rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
      step();
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL reset_idle got=%h exp=%h", got, exp_v); end
   endtask

   task automatic test_enable();
      enable = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         exp_v = {4'b1000, 8'd8};
         checks++;
         if (got !== exp_v) begin failures++; $display("FAIL enable k=%0d got=%h exp=%h", k, got, exp_v); end
      end
   endtask

   task automatic test_switch();
      logic en_e;
      cfg_valid = 1'b1; cfg_ratio = 8'd6;
      step();
      cfg_valid = 1'b0;
      for (int k = 1; k <= G + 3; k++) begin
         en_e  = (G == 0) ? 1'b1 : (k >= G + 2);
         exp_v = {en_e, (k <= G + 1), (k == G + 2), 1'b0, (k >= G + 1) ? 8'd6 : 8'd8};
         checks++;
         if (got !== exp_v) begin failures++; $display("FAIL switch k=%0d got=%h exp=%h", k, got, exp_v); end
         step();
      end
   endtask

   task automatic test_equal();
      cfg_valid = 1'b1; cfg_ratio = 8'd6;
      step();
      cfg_valid = 1'b0;
      exp_v = {4'b1010, 8'd6};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL equal_pulse got=%h exp=%h", got, exp_v); end
      step();
      exp_v = {4'b1000, 8'd6};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL equal_after got=%h exp=%h", got, exp_v); end
   endtask

   task automatic test_cfg_err();
      cfg_valid = 1'b1; cfg_ratio = 8'd1;
      step();
      exp_v = {4'b1001, 8'd6};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL err_ratio1 got=%h exp=%h", got, exp_v); end
      cfg_ratio = 8'd0;
      step();
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL err_ratio0 got=%h exp=%h", got, exp_v); end
      cfg_valid = 1'b0; err_clr = 1'b1;
      step();
      exp_v = {4'b1000, 8'd6};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL err_clear got=%h exp=%h", got, exp_v); end
      cfg_valid = 1'b1; cfg_ratio = 8'd1;
      step();
      exp_v = {4'b1001, 8'd6};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL err_set_wins got=%h exp=%h", got, exp_v); end
      cfg_valid = 1'b0;
      step();
      err_clr = 1'b0;
      exp_v = {4'b1000, 8'd6};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL err_clear2 got=%h exp=%h", got, exp_v); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] r_e;
      logic       en_e, busy_e;
      cfg_valid = 1'b1; cfg_ratio = 8'd9;
      step();
      for (int k = 1; k <= 2 * G + 5; k++) begin
         cfg_valid = (k == D);
         cfg_ratio = 8'd14;
         r_e    = (k < G + 1) ? 8'd6 : ((k < 2 * G + 3) ? 8'd9 : 8'd14);
         en_e   = (G == 0) ? 1'b1 : ((k == G + 2) || (k >= 2 * G + 4));
         busy_e = ((k >= 1) && (k <= G + 1)) || ((k >= G + 3) && (k <= 2 * G + 3));
         exp_v  = {en_e, busy_e, (k == G + 2) || (k == 2 * G + 4), 1'b0, r_e};
         checks++;
         if (got !== exp_v) begin failures++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, exp_v); end
         step();
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_enable_drop();
      cfg_valid = 1'b1; cfg_ratio = 8'd5;
      step();
      cfg_valid = 1'b0;
      for (int k = 1; k <= G + 3; k++) begin
         if (k >= D) enable = 1'b0;
         exp_v = {(G == 0) && (k == 1), (k <= G + 1), (k == G + 2), 1'b0, (k >= G + 1) ? 8'd5 : 8'd14};
         checks++;
         if (got !== exp_v) begin failures++; $display("FAIL enable_drop k=%0d got=%h exp=%h", k, got, exp_v); end
         step();
      end
   endtask

   task automatic test_idle_write();
      cfg_valid = 1'b1; cfg_ratio = 8'd7;
      step();
      cfg_valid = 1'b0;
      exp_v = {4'b0010, 8'd7};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL idle_write got=%h exp=%h", got, exp_v); end
      step();
      exp_v = {4'b0000, 8'd7};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL idle_after got=%h exp=%h", got, exp_v); end
   endtask

   task automatic test_reset_mid_switch();
      enable = 1'b1;
      step();
      exp_v = {4'b1000, 8'd7};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL rst_pre_run got=%h exp=%h", got, exp_v); end
      cfg_valid = 1'b1; cfg_ratio = 8'd11;
      step();
      cfg_ratio = 8'd12;
      exp_v = (G > 0) ? {4'b0100, 8'd7} : {4'b1100, 8'd11};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL rst_in_switch got=%h exp=%h", got, exp_v); end
      repeat (D - 1) step();
      cfg_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_v = {4'b0000, 8'd8};
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL rst_abort got=%h exp=%h", got, exp_v); end
      for (int k = 1; k <= G + 3; k++) begin
         step();
         exp_v = {4'b1000, 8'd8};
         checks++;
         if (got !== exp_v) begin failures++; $display("FAIL rst_no_pending k=%0d got=%h exp=%h", k, got, exp_v); end
      end
   endtask

   initial begin
      test_reset();
      test_enable();
      test_switch();
      test_equal();
      test_cfg_err();
      test_back_to_back();
      test_enable_drop();
      test_idle_write();
      test_reset_mid_switch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
